// File: rtl/sdram_req_arbiter.sv
// Serialises the IOCTL download path and N_CLI fixed-priority read clients onto one SDRAM port, one transaction at a time.
// Outputs are registered, with one cycle from IDLE to sdram_req. Define STARVE_GUARD_EN to enable age-based starvation promotion.
module sdram_req_arbiter #(
  parameter int N_CLI        = 3,
  parameter int AW           = 23,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                dl_active_i,
  input  logic                dl_req_i,
  input  logic [AW-1:0]       dl_addr_i,
  input  logic [31:0]         dl_data_i,
  output logic                dl_ack_o,
  input  logic [N_CLI-1:0]    cli_req_i,
  input  logic [N_CLI*AW-1:0] cli_addr_i,
  output logic [N_CLI-1:0]    cli_ack_o,
  output logic [N_CLI-1:0]    cli_valid_o,
  output logic [31:0]         cli_data_o,
  output logic [AW-1:0]       sdram_addr_o,
  output logic [31:0]         sdram_data_o,
  output logic                sdram_we_o,
  output logic                sdram_req_o,
  input  logic                sdram_ack_i,
  input  logic                sdram_valid_i,
  input  logic [31:0]         sdram_q_i,
  output logic                busy_o,
  output logic                timeout_err_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state_q;
  logic               own_dl_q;
  logic [N_CLI-1:0]   owner_oh_q;
  logic [7:0]         wait_cnt_q;
  logic               dl_ack_q;
  logic [N_CLI-1:0]   cli_ack_q;
  logic [N_CLI-1:0]   cli_valid_q;
  logic [31:0]        cli_data_q;
  logic [AW-1:0]      sdram_addr_q;
  logic [31:0]        sdram_data_q;
  logic               sdram_we_q;
  logic               sdram_req_q;
  logic               timeout_err_q;

  logic [N_CLI-1:0]   cand;
  logic [N_CLI-1:0]   win_oh;
  logic [AW-1:0]      win_addr;
  logic               grant_cli;

  // Client grants are only issued from IDLE and only while no download is running.
  assign grant_cli = (state_q == S_IDLE) && !dl_active_i && (|cli_req_i);

`ifdef STARVE_GUARD_EN
  logic [3:0]       age_q [N_CLI];
  logic [3:0]       age_d [N_CLI];
  logic [N_CLI-1:0] starved;

  always_comb begin
    starved = '0;
    for (int i = 0; i < N_CLI; i++) begin
      starved[i] = cli_req_i[i] && (age_q[i] >= 4'(STARVE_LIMIT));
    end
  end

  assign cand = (|starved) ? starved : cli_req_i;

  always_comb begin
    for (int i = 0; i < N_CLI; i++) begin
      age_d[i] = age_q[i];
      if (!cli_req_i[i] || (grant_cli && win_oh[i])) begin
        age_d[i] = 4'd0;
      end else if (state_q == S_IDLE && age_q[i] != 4'hF) begin
        age_d[i] = age_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CLI; i++) begin
      if (!reset_n_i) age_q[i] <= 4'd0;
      else            age_q[i] <= age_d[i];
    end
  end
`else
  assign cand = cli_req_i;
`endif

  // Isolate the lowest set bit: lowest index wins.
  assign win_oh = cand & (~cand + {{(N_CLI-1){1'b0}}, 1'b1});

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_CLI; i++) begin
      if (win_oh[i]) win_addr = cli_addr_i[i*AW +: AW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      own_dl_q      <= 1'b0;
      owner_oh_q    <= '0;
      wait_cnt_q    <= 8'd0;
      dl_ack_q      <= 1'b0;
      cli_ack_q     <= '0;
      cli_valid_q   <= '0;
      cli_data_q    <= 32'd0;
      sdram_addr_q  <= '0;
      sdram_data_q  <= 32'd0;
      sdram_we_q    <= 1'b0;
      sdram_req_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      dl_ack_q    <= 1'b0;
      cli_ack_q   <= '0;
      cli_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (dl_active_i) begin
            if (dl_req_i) begin
              sdram_addr_q <= dl_addr_i;
              sdram_data_q <= dl_data_i;
              sdram_we_q   <= 1'b1;
              sdram_req_q  <= 1'b1;
              own_dl_q     <= 1'b1;
              owner_oh_q   <= '0;
              state_q      <= S_REQ;
            end
          end else if (grant_cli) begin
            sdram_addr_q <= win_addr;
            sdram_we_q   <= 1'b0;
            sdram_req_q  <= 1'b1;
            own_dl_q     <= 1'b0;
            owner_oh_q   <= win_oh;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (sdram_ack_i) begin
            sdram_req_q <= 1'b0;
            // The wait counter counts WAIT cycles including the current one.
            wait_cnt_q  <= 8'd1;
            if (own_dl_q) begin
              dl_ack_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              cli_ack_q <= owner_oh_q;
              if (sdram_valid_i) begin
                cli_data_q  <= sdram_q_i;
                cli_valid_q <= owner_oh_q;
                state_q     <= S_IDLE;
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (sdram_valid_i) begin
            cli_data_q  <= sdram_q_i;
            cli_valid_q <= owner_oh_q;
            state_q     <= S_IDLE;
          end else if (wait_cnt_q == TIMEOUT_C) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dl_ack_o      = dl_ack_q;
  assign cli_ack_o     = cli_ack_q;
  assign cli_valid_o   = cli_valid_q;
  assign cli_data_o    = cli_data_q;
  assign sdram_addr_o  = sdram_addr_q;
  assign sdram_data_o  = sdram_data_q;
  assign sdram_we_o    = sdram_we_q;
  assign sdram_req_o   = sdram_req_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: a vector table for reset/read/ack+valid cases plus
// hand-written download, timeout and starvation sequences.
module tb_sdram_req_arbiter;

  localparam logic [22:0] A0 = 23'h000100;
  localparam logic [22:0] A1 = 23'h060000;
  localparam logic [22:0] A2 = 23'h7F0002;
  localparam int NV = 20;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, dl_active, dl_req, dl_ack;
  logic [22:0] dl_addr;
  logic [31:0] dl_data;
  logic [2:0]  cli_req, cli_ack, cli_valid;
  logic [68:0] cli_addr;
  logic [31:0] cli_data;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data, sdram_q;
  logic        sdram_we, sdram_req, sdram_ack, sdram_valid;
  logic        busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  sdram_req_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dl_active_i(dl_active), .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_ack_o(dl_ack),
    .cli_req_i(cli_req), .cli_addr_i(cli_addr), .cli_ack_o(cli_ack), .cli_valid_o(cli_valid), .cli_data_o(cli_data),
    .sdram_addr_o(sdram_addr), .sdram_data_o(sdram_data), .sdram_we_o(sdram_we), .sdram_req_o(sdram_req),
    .sdram_ack_i(sdram_ack), .sdram_valid_i(sdram_valid), .sdram_q_i(sdram_q),
    .busy_o(busy), .timeout_err_o(timeout_err)
  );

  typedef struct {
    logic        rst_n;
    logic        dl_act;
    logic [2:0]  req;
    logic        ack;
    logic        vld;
    logic [31:0] q;
    logic        e_sreq;
    logic [22:0] e_addr;
    logic [2:0]  e_cack;
    logic [2:0]  e_cvld;
    logic [31:0] e_cdata;
    logic        e_busy;
  } vec_t;

  vec_t tv [NV];

  function automatic vec_t mk(input logic r, input logic da, input logic [2:0] rq, input logic ak,
                              input logic vl, input logic [31:0] qq, input logic es, input logic [22:0] ea,
                              input logic [2:0] eck, input logic [2:0] ecv, input logic [31:0] ecd,
                              input logic eb);
    vec_t v;
    v.rst_n = r;   v.dl_act = da;  v.req = rq;     v.ack = ak;     v.vld = vl;      v.q = qq;
    v.e_sreq = es; v.e_addr = ea;  v.e_cack = eck; v.e_cvld = ecv; v.e_cdata = ecd; v.e_busy = eb;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cack_seen;
    int n_dlack;
    int k;
    int cvld_seen;
    int npulse;
    int first2;

    reset_n = 1'b0; dl_active = 1'b0; dl_req = 1'b0; dl_addr = '0; dl_data = '0;
    cli_req = '0; cli_addr = {A2, A1, A0};
    sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;

    //          rst da  req    ak vl q              sreq addr cack    cvld    cdata          busy
    tv[0]  = mk(0, 0, 3'b111, 0, 0, 32'h0,         0, 23'h0, 3'b000, 3'b000, 32'h0,         0);
    tv[1]  = mk(0, 0, 3'b111, 0, 0, 32'h0,         0, 23'h0, 3'b000, 3'b000, 32'h0,         0);
    tv[2]  = mk(1, 0, 3'b111, 0, 0, 32'h0,         1, A0,    3'b000, 3'b000, 32'h0,         1);
    tv[3]  = mk(1, 0, 3'b111, 0, 0, 32'h0,         1, A0,    3'b000, 3'b000, 32'h0,         1);
    tv[4]  = mk(1, 0, 3'b111, 1, 0, 32'h0,         0, A0,    3'b001, 3'b000, 32'h0,         1);
    tv[5]  = mk(1, 0, 3'b010, 0, 0, 32'h0,         0, A0,    3'b000, 3'b000, 32'h0,         1);
    tv[6]  = mk(1, 0, 3'b010, 0, 1, 32'hCAFE0000,  0, A0,    3'b000, 3'b001, 32'hCAFE0000,  0);
    tv[7]  = mk(1, 0, 3'b010, 0, 0, 32'h0,         1, A1,    3'b000, 3'b000, 32'hCAFE0000,  1);
    tv[8]  = mk(1, 0, 3'b010, 0, 0, 32'h0,         1, A1,    3'b000, 3'b000, 32'hCAFE0000,  1);
    tv[9]  = mk(1, 0, 3'b010, 1, 0, 32'h0,         0, A1,    3'b010, 3'b000, 32'hCAFE0000,  1);
    tv[10] = mk(1, 0, 3'b000, 0, 0, 32'h0,         0, A1,    3'b000, 3'b000, 32'hCAFE0000,  1);
    tv[11] = mk(1, 0, 3'b000, 0, 0, 32'h0,         0, A1,    3'b000, 3'b000, 32'hCAFE0000,  1);
    tv[12] = mk(1, 0, 3'b000, 0, 1, 32'hDEADBEEF,  0, A1,    3'b000, 3'b010, 32'hDEADBEEF,  0);
    tv[13] = mk(1, 0, 3'b000, 0, 1, 32'h12345678,  0, A1,    3'b000, 3'b000, 32'hDEADBEEF,  0);
    tv[14] = mk(1, 0, 3'b100, 0, 0, 32'h0,         1, A2,    3'b000, 3'b000, 32'hDEADBEEF,  1);
    tv[15] = mk(1, 0, 3'b100, 1, 1, 32'hA5A5A5A5,  0, A2,    3'b100, 3'b100, 32'hA5A5A5A5,  0);
    tv[16] = mk(1, 0, 3'b000, 0, 0, 32'h0,         0, A2,    3'b000, 3'b000, 32'hA5A5A5A5,  0);
    tv[17] = mk(1, 0, 3'b001, 0, 0, 32'h0,         1, A0,    3'b000, 3'b000, 32'hA5A5A5A5,  1);
    tv[18] = mk(0, 0, 3'b001, 0, 0, 32'h0,         0, 23'h0, 3'b000, 3'b000, 32'h0,         0);
    tv[19] = mk(1, 0, 3'b000, 0, 0, 32'h0,         0, 23'h0, 3'b000, 3'b000, 32'h0,         0);

    for (int i = 0; i < NV; i++) begin
      reset_n = tv[i].rst_n; dl_active = tv[i].dl_act; cli_req = tv[i].req;
      sdram_ack = tv[i].ack; sdram_valid = tv[i].vld; sdram_q = tv[i].q;
      step();
      check($sformatf("v%0d sdram_req", i), 32'(sdram_req), 32'(tv[i].e_sreq));
      check($sformatf("v%0d sdram_addr", i), 32'(sdram_addr), 32'(tv[i].e_addr));
      check($sformatf("v%0d cli_ack", i), 32'(cli_ack), 32'(tv[i].e_cack));
      check($sformatf("v%0d cli_valid", i), 32'(cli_valid), 32'(tv[i].e_cvld));
      check($sformatf("v%0d cli_data", i), cli_data, tv[i].e_cdata);
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
      check($sformatf("v%0d sdram_we", i), 32'(sdram_we), 32'(0));
      check($sformatf("v%0d dl_ack", i), 32'(dl_ack), 32'(0));
      check($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(0));
    end
    sdram_ack = 1'b0; sdram_valid = 1'b0;

    // Download: four writes while client 0 keeps requesting.
    dl_active = 1'b1; cli_req = 3'b001; cack_seen = 0; n_dlack = 0;
    for (int w = 0; w < 4; w++) begin
      dl_req = 1'b1; dl_addr = 23'(w); dl_data = 32'(w + 1);
      k = 0;
      while (!sdram_req && k < 10) begin
        step();
        if (cli_ack != 3'b000) cack_seen++;
        k++;
      end
      check($sformatf("dl%0d sdram_req", w), 32'(sdram_req), 32'(1));
      check($sformatf("dl%0d sdram_addr", w), 32'(sdram_addr), 32'(w));
      check($sformatf("dl%0d sdram_data", w), sdram_data, 32'(w + 1));
      check($sformatf("dl%0d sdram_we", w), 32'(sdram_we), 32'(1));
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0; dl_req = 1'b0;
      if (dl_ack) n_dlack++;
      if (cli_ack != 3'b000) cack_seen++;
      check($sformatf("dl%0d req_drop", w), 32'(sdram_req), 32'(0));
      step();
      check($sformatf("dl%0d dl_ack_pulse", w), 32'(dl_ack), 32'(0));
      if (cli_ack != 3'b000) cack_seen++;
    end
    for (int j = 0; j < 3; j++) begin
      step();
      if (cli_ack != 3'b000 || sdram_req) cack_seen++;
    end
    check("dl n_dl_ack", 32'(n_dlack), 32'(4));
    check("dl no_client_grant", 32'(cack_seen), 32'(0));
    check("dl idle_busy", 32'(busy), 32'(0));
    dl_active = 1'b0;
    step();
    check("post_dl grant_req", 32'(sdram_req), 32'(1));
    check("post_dl grant_addr", 32'(sdram_addr), 32'(A0));
    check("post_dl grant_we", 32'(sdram_we), 32'(0));
    sdram_ack = 1'b1; sdram_valid = 1'b1; sdram_q = 32'h11112222;
    step();
    check("post_dl cli_ack", 32'(cli_ack), 32'(3'b001));
    check("post_dl cli_valid", 32'(cli_valid), 32'(3'b001));
    check("post_dl cli_data", cli_data, 32'h11112222);
    cli_req = 3'b000; sdram_ack = 1'b0; sdram_valid = 1'b0;
    step();

    // Timeout: acknowledged read that never returns data.
    cli_req = 3'b010;
    step();
    sdram_ack = 1'b1;
    step();
    check("to cli_ack", 32'(cli_ack), 32'(3'b010));
    cli_req = 3'b000; sdram_ack = 1'b0;
    k = 0; cvld_seen = 0;
    while (!timeout_err && k < 300) begin
      step();
      if (cli_valid != 3'b000) cvld_seen++;
      k++;
    end
    check("to cycles_to_err", 32'(k), 32'(255));
    check("to timeout_err", 32'(timeout_err), 32'(1));
    check("to no_cli_valid", 32'(cvld_seen), 32'(0));
    check("to busy_after", 32'(busy), 32'(0));
    cli_req = 3'b001;
    step();
    check("to next_req", 32'(sdram_req), 32'(1));
    check("to next_addr", 32'(sdram_addr), 32'(A0));
    sdram_ack = 1'b1; sdram_valid = 1'b1; sdram_q = 32'h0BADF00D;
    step();
    check("to next_valid", 32'(cli_valid), 32'(3'b001));
    check("to sticky", 32'(timeout_err), 32'(1));
    cli_req = 3'b000; sdram_ack = 1'b0; sdram_valid = 1'b0;
    step();

    // Starvation: client 0 requests continuously against a held client 2.
    cli_req = 3'b101; sdram_ack = 1'b1; sdram_valid = 1'b1; sdram_q = 32'h600D600D;
    npulse = 0; first2 = 0;
    for (int s = 0; s < 40; s++) begin
      step();
      if (cli_ack != 3'b000) begin
        npulse++;
        if (cli_ack[2] && first2 == 0) first2 = npulse;
      end
    end
`ifdef STARVE_GUARD_EN
    check("starve c2_first_grant", 32'(first2), 32'(16));
`else
    check("fixed_prio c2_never_granted", 32'(first2), 32'(0));
`endif
    check("starve arbitrations", 32'(npulse), 32'(20));
    cli_req = 3'b000; sdram_ack = 1'b0; sdram_valid = 1'b0;
    step();
    step();
    check("final busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
